// File: rtl/vga_pkg.sv
// Shared VGA constants, source count and arbiter state encoding for the
// 640x480 video path.
package vga_pkg;

    // 640x480 @ 60 Hz frame geometry
    localparam int TOTAL_COLS  = 800;
    localparam int TOTAL_ROWS  = 525;
    localparam int ACTIVE_COLS = 640;
    localparam int ACTIVE_ROWS = 480;

    // Porch and sync widths used by the downstream sync/porch stage
    localparam int H_FRONT_PORCH = 16;
    localparam int H_SYNC_WIDTH  = 96;
    localparam int H_BACK_PORCH  = 48;
    localparam int V_FRONT_PORCH = 10;
    localparam int V_SYNC_WIDTH  = 2;
    localparam int V_BACK_PORCH  = 33;

    // Number of video-pattern requesters sharing the output
    localparam int NUM_SRC = 4;

    // Width of the column/row counters
    localparam int COUNT_WIDTH = 10;

    // Arbiter states: no owner, or exactly one owner for the current frame
    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_OWN  = 1'b1
    } arb_state_t;

    // Converts a one-hot source vector into its source index
    function automatic logic [1:0] onehot_to_idx(input logic [NUM_SRC-1:0] oh);
        logic [1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (oh[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter_4.sv
// Combinational round-robin pick among four requesters. The search starts at
// the source after last_owner and wraps, so the previous owner is considered
// last and only wins when nobody else is asking.
module rr_arbiter_4
    import vga_pkg::*;
(
    input  logic [NUM_SRC-1:0] req,
    input  logic [1:0]         last_owner,
    output logic [NUM_SRC-1:0] grant,
    output logic               valid
);

    logic [1:0] idx;

    // Walk the sources in rotating priority order and take the first requester
    always_comb begin
        grant = '0;
        valid = 1'b0;
        idx   = '0;
        for (int i = 1; i <= NUM_SRC; i++) begin
            idx = last_owner + 2'(i);
            if (!valid && req[idx]) begin
                grant[idx] = 1'b1;
                valid      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vga_frame_arbiter.sv
// Frame-synchronous timing master and source arbiter: generates active-region
// sync and counts, and hands the single VGA output to one of four sources for
// whole frames at a time so that a frame is never torn.
module vga_frame_arbiter
    import vga_pkg::*;
#(
    parameter int VIDEO_WIDTH = 3,
    parameter int TOTAL_COLS  = vga_pkg::TOTAL_COLS,
    parameter int TOTAL_ROWS  = vga_pkg::TOTAL_ROWS,
    parameter int ACTIVE_COLS = vga_pkg::ACTIVE_COLS,
    parameter int ACTIVE_ROWS = vga_pkg::ACTIVE_ROWS
) (
    input  logic                           i_Clk,
    input  logic                           i_Rst,
    input  logic [NUM_SRC-1:0]             i_Req,
    input  logic [NUM_SRC*VIDEO_WIDTH-1:0] i_Red_Video,
    input  logic [NUM_SRC*VIDEO_WIDTH-1:0] i_Grn_Video,
    input  logic [NUM_SRC*VIDEO_WIDTH-1:0] i_Blu_Video,
    output logic                           o_HSync,
    output logic                           o_VSync,
    output logic [COUNT_WIDTH-1:0]         o_Col_Count,
    output logic [COUNT_WIDTH-1:0]         o_Row_Count,
    output logic                           o_Frame_Start,
    output logic [NUM_SRC-1:0]             o_Grant,
    output logic [VIDEO_WIDTH-1:0]         o_Red_Video,
    output logic [VIDEO_WIDTH-1:0]         o_Grn_Video,
    output logic [VIDEO_WIDTH-1:0]         o_Blu_Video
);

    localparam logic [COUNT_WIDTH-1:0] LAST_COL = COUNT_WIDTH'(TOTAL_COLS - 1);
    localparam logic [COUNT_WIDTH-1:0] LAST_ROW = COUNT_WIDTH'(TOTAL_ROWS - 1);
    localparam logic [COUNT_WIDTH-1:0] ACT_COLS = COUNT_WIDTH'(ACTIVE_COLS);
    localparam logic [COUNT_WIDTH-1:0] ACT_ROWS = COUNT_WIDTH'(ACTIVE_ROWS);

    // Internal position; reset parks it on the last pixel so the first clock
    // after release lands on (0,0) and triggers a frame-boundary arbitration.
    logic [COUNT_WIDTH-1:0] col_q;
    logic [COUNT_WIDTH-1:0] row_q;
    logic [COUNT_WIDTH-1:0] next_col;
    logic [COUNT_WIDTH-1:0] next_row;
    logic                   wrap;

    arb_state_t             state;
    logic [1:0]             last_owner;
    logic [NUM_SRC-1:0]     pick_grant;
    logic                   pick_valid;

    logic [VIDEO_WIDTH-1:0] sel_red;
    logic [VIDEO_WIDTH-1:0] sel_grn;
    logic [VIDEO_WIDTH-1:0] sel_blu;
    logic                   show_pixel;

    // Next position and detection of the wrap back to (0,0)
    always_comb begin
        wrap     = (col_q == LAST_COL) && (row_q == LAST_ROW);
        next_col = (col_q == LAST_COL) ? '0 : col_q + 1'b1;
        next_row = row_q;
        if (col_q == LAST_COL) begin
            next_row = (row_q == LAST_ROW) ? '0 : row_q + 1'b1;
        end
    end

    // Free-running column/row position
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            col_q <= LAST_COL;
            row_q <= LAST_ROW;
        end else begin
            col_q <= next_col;
            row_q <= next_row;
        end
    end

    // Published counts, active-region syncs and frame-start pulse, all updated together
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            o_Col_Count   <= '0;
            o_Row_Count   <= '0;
            o_HSync       <= 1'b0;
            o_VSync       <= 1'b0;
            o_Frame_Start <= 1'b0;
        end else begin
            o_Col_Count   <= next_col;
            o_Row_Count   <= next_row;
            o_HSync       <= (next_col < ACT_COLS);
            o_VSync       <= (next_row < ACT_ROWS);
            o_Frame_Start <= wrap;
        end
    end

    rr_arbiter_4 u_rr_arbiter (
        .req        (i_Req),
        .last_owner (last_owner),
        .grant      (pick_grant),
        .valid      (pick_valid)
    );

    // Ownership FSM, only re-evaluated on the frame wrap so a frame is never torn
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state      <= ARB_IDLE;
            o_Grant    <= '0;
            last_owner <= 2'd3;
        end else if (wrap) begin
            if (pick_valid) begin
                state      <= ARB_OWN;
                o_Grant    <= pick_grant;
                last_owner <= onehot_to_idx(pick_grant);
            end else begin
                state      <= ARB_IDLE;
                o_Grant    <= '0;
            end
        end
    end

    // Select the current owner's pixel and decide whether it is visible
    always_comb begin
        sel_red    = '0;
        sel_grn    = '0;
        sel_blu    = '0;
        show_pixel = o_HSync && o_VSync && (state == ARB_OWN);
        for (int n = 0; n < NUM_SRC; n++) begin
            if (o_Grant[n]) begin
                sel_red = i_Red_Video[n*VIDEO_WIDTH +: VIDEO_WIDTH];
                sel_grn = i_Grn_Video[n*VIDEO_WIDTH +: VIDEO_WIDTH];
                sel_blu = i_Blu_Video[n*VIDEO_WIDTH +: VIDEO_WIDTH];
            end
        end
    end

    // Register the blanked video one cycle behind the counts that produced it
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            o_Red_Video <= '0;
            o_Grn_Video <= '0;
            o_Blu_Video <= '0;
        end else begin
            o_Red_Video <= show_pixel ? sel_red : '0;
            o_Grn_Video <= show_pixel ? sel_grn : '0;
            o_Blu_Video <= show_pixel ? sel_blu : '0;
        end
    end

endmodule

// File: tb/tb_vga_frame_arbiter.sv
// Scoreboard bench for vga_frame_arbiter on a shrunken 10x6 frame with a 6x4
// active region. A reference model derives every expected output from the
// cycle index since reset release and the per-frame round-robin rule.
module tb_vga_frame_arbiter;

    localparam int VW = 3;
    localparam int TC = 10;
    localparam int TR = 6;
    localparam int AC = 6;
    localparam int AR = 4;

    logic        clk;
    logic        rst;
    logic [3:0]  i_req;
    logic [11:0] i_red;
    logic [11:0] i_grn;
    logic [11:0] i_blu;
    logic        o_hsync;
    logic        o_vsync;
    logic [9:0]  o_col;
    logic [9:0]  o_row;
    logic        o_fs;
    logic [3:0]  o_grant;
    logic [2:0]  o_red;
    logic [2:0]  o_grn;
    logic [2:0]  o_blu;

    typedef struct {
        int         col;
        int         row;
        logic       hs;
        logic       vs;
        logic       fs;
        logic [3:0] grant;
        logic [2:0] r;
        logic [2:0] g;
        logic [2:0] b;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    // Reference model state: cycle index since release and per-frame owner
    bit          m_started;
    int          m_n;
    int          m_col;
    int          m_row;
    int          m_last;
    logic [3:0]  m_grant;
    logic        m_prev_hs;
    logic        m_prev_vs;
    logic [3:0]  m_prev_grant;
    logic [3:0]  a_req;
    logic [11:0] a_red;
    logic [11:0] a_grn;
    logic [11:0] a_blu;

    vga_frame_arbiter #(
        .VIDEO_WIDTH (VW),
        .TOTAL_COLS  (TC),
        .TOTAL_ROWS  (TR),
        .ACTIVE_COLS (AC),
        .ACTIVE_ROWS (AR)
    ) dut (
        .i_Clk         (clk),
        .i_Rst         (rst),
        .i_Req         (i_req),
        .i_Red_Video   (i_red),
        .i_Grn_Video   (i_grn),
        .i_Blu_Video   (i_blu),
        .o_HSync       (o_hsync),
        .o_VSync       (o_vsync),
        .o_Col_Count   (o_col),
        .o_Row_Count   (o_row),
        .o_Frame_Start (o_fs),
        .o_Grant       (o_grant),
        .o_Red_Video   (o_red),
        .o_Grn_Video   (o_grn),
        .o_Blu_Video   (o_blu)
    );

    // 10 ns pixel clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison with a FAIL line on mismatch
    task automatic cmp(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp_v);
        end
    endtask

    // Compare every DUT output against one expected record
    task automatic checkOutput(input exp_t e);
        cmp("col", int'(o_col), e.col);
        cmp("row", int'(o_row), e.row);
        cmp("hsync", int'(o_hsync), int'(e.hs));
        cmp("vsync", int'(o_vsync), int'(e.vs));
        cmp("frame_start", int'(o_fs), int'(e.fs));
        cmp("grant", int'(o_grant), int'(e.grant));
        cmp("red", int'(o_red), int'(e.r));
        cmp("grn", int'(o_grn), int'(e.g));
        cmp("blu", int'(o_blu), int'(e.b));
    endtask

    // Forget everything the model knew; the last owner restarts at source 3
    task automatic modelReset();
        m_started    = 1'b0;
        m_n          = 0;
        m_col        = 0;
        m_row        = 0;
        m_last       = 3;
        m_grant      = '0;
        m_prev_hs    = 1'b0;
        m_prev_vs    = 1'b0;
        m_prev_grant = '0;
    endtask

    // Advance the model by one clock using the inputs applied before that clock
    task automatic modelStep();
        exp_t e;
        int   src;
        bit   found;
        int   idx;
        if (!m_started) begin
            m_n       = 0;
            m_started = 1'b1;
        end else begin
            m_n++;
        end
        e.r = '0;
        e.g = '0;
        e.b = '0;
        if (m_prev_hs && m_prev_vs && m_prev_grant != 4'b0000) begin
            src = 0;
            for (int s = 0; s < 4; s++) if (m_prev_grant[s]) src = s;
            e.r = a_red[src*VW +: VW];
            e.g = a_grn[src*VW +: VW];
            e.b = a_blu[src*VW +: VW];
        end
        m_col = m_n % TC;
        m_row = (m_n / TC) % TR;
        if (m_col == 0 && m_row == 0) begin
            found = 1'b0;
            for (int k = 1; k <= 4; k++) begin
                idx = (m_last + k) % 4;
                if (!found && a_req[idx]) begin
                    found   = 1'b1;
                    m_grant = 4'(1 << idx);
                    m_last  = idx;
                end
            end
            if (!found) m_grant = '0;
        end
        e.col   = m_col;
        e.row   = m_row;
        e.hs    = (m_col < AC);
        e.vs    = (m_row < AR);
        e.fs    = (m_col == 0 && m_row == 0);
        e.grant = m_grant;
        sb.push_back(e);
        m_prev_hs    = e.hs;
        m_prev_vs    = e.vs;
        m_prev_grant = m_grant;
    endtask

    // Drive the DUT inputs and remember them for the model
    task automatic driveInputs(input logic [3:0] req, input logic [11:0] r,
                               input logic [11:0] g, input logic [11:0] b);
        i_req = req;
        i_red = r;
        i_grn = g;
        i_blu = b;
        a_req = req;
        a_red = r;
        a_grn = g;
        a_blu = b;
    endtask

    // One clock: predict the outputs it produced, then apply the next inputs
    task automatic applyStimulus(input logic [3:0] req, input logic [11:0] r,
                                 input logic [11:0] g, input logic [11:0] b);
        @(posedge clk);
        #1;
        modelStep();
        driveInputs(req, r, g, b);
    endtask

    // Assert reset between edges, confirm outputs clear at once, then release
    task automatic doReset(input logic [3:0] req_during);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        sb.delete();
        cmp("rst_col", int'(o_col), 0);
        cmp("rst_row", int'(o_row), 0);
        cmp("rst_sync", int'({o_hsync, o_vsync, o_fs}), 0);
        cmp("rst_grant", int'(o_grant), 0);
        cmp("rst_video", int'({o_red, o_grn, o_blu}), 0);
        driveInputs(req_during, 12'($urandom), 12'($urandom), 12'($urandom));
        repeat (3) @(posedge clk);
        @(negedge clk);
        modelReset();
        rst = 1'b0;
    endtask

    function automatic logic [11:0] rv();
        return 12'($urandom);
    endfunction

    // Monitor: every clock presents a full set of outputs; pop and compare
    always @(negedge clk) begin
        if (!rst && sb.size() > 0) begin
            checkOutput(sb.pop_front());
        end
    end

    initial begin
        logic [11:0] red;
        bit          dropped;
        bit          reached;
        rst = 1'b1;
        modelReset();
        driveInputs(4'b0000, rv(), rv(), rv());

        // Idle frame: no requests, no grant, video stays dark
        doReset(4'b0000);
        repeat (62) applyStimulus(4'b0000, rv(), rv(), rv());

        // Single requester 1 with red fixed at 5 on its lane
        for (int c = 0; c < 130; c++) begin
            red      = rv();
            red[5:3] = 3'd5;
            applyStimulus(4'b0010, red, rv(), rv());
        end

        // Two requesters alternate frame by frame starting with source 0
        doReset(4'b0101);
        repeat (180) applyStimulus(4'b0101, rv(), rv(), rv());

        // Owner 1 drops its request mid-frame; it keeps the frame then goes idle
        dropped = 1'b0;
        for (int c = 0; c < 150; c++) begin
            if (m_grant == 4'b0010 && m_col == 3 && m_row == 2) dropped = 1'b1;
            applyStimulus(dropped ? 4'b0000 : 4'b0010, rv(), rv(), rv());
        end
        if (!dropped) cmp("drop_reached", 0, 1);

        // A request pulse away from the wrap is ignored
        for (int c = 0; c < 130; c++) begin
            applyStimulus((m_col == 5 && m_row == 5) ? 4'b1000 : 4'b0000, rv(), rv(), rv());
        end

        // Reset in the middle of an owned frame, then all four request
        reached = 1'b0;
        for (int c = 0; c < 200 && !reached; c++) begin
            applyStimulus(4'b0001, rv(), rv(), rv());
            if (m_grant != 4'b0000 && m_col == 4 && m_row == 3) reached = 1'b1;
        end
        if (!reached) cmp("own_reached", 0, 1);
        doReset(4'b1111);
        repeat (130) applyStimulus(4'b1111, rv(), rv(), rv());

        // Random requests and pixels over several frames
        for (int c = 0; c < 600; c++) begin
            applyStimulus(4'($urandom_range(0, 15)), rv(), rv(), rv());
        end

        @(negedge clk);
        #1;
        cmp("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_frame_arbiter.md
# vga_frame_arbiter

Frame-synchronous timing master and source arbiter for the VGA output path. It generates the raw active-region HSync/VSync pulses and column/row counts, and shares the single VGA output among four video-pattern requesters with round-robin arbitration. Ownership changes only at frame boundaries, so a frame is never torn. Its sync and video outputs feed the existing sync/porch stage directly.

## Interface
- VIDEO_WIDTH, 3, bits per colour channel
- TOTAL_COLS, 800, pixels per line including blanking
- TOTAL_ROWS, 525, lines per frame including blanking
- ACTIVE_COLS, 640, visible pixels per line
- ACTIVE_ROWS, 480, visible lines per frame
- i_Clk  in  1  pixel clock (25 MHz for 640x480)
- i_Rst  in  1  reset; asynchronous, active-high
- i_Req  in  4  per-source request level; bit n = source n
- i_Red_Video  in  4*VIDEO_WIDTH  source n occupies bits [n*VIDEO_WIDTH +: VIDEO_WIDTH]; i_Grn_Video and i_Blu_Video use the same layout
- o_HSync  out  1  high while the column is below ACTIVE_COLS
- o_VSync  out  1  high while the row is below ACTIVE_ROWS
- o_Col_Count  out  10  current column
- o_Row_Count  out  10  current row
- o_Frame_Start  out  1  one-cycle pulse at count (0,0)
- o_Grant  out  4  one-hot owner of the current frame; all-zero means none
- o_Red_Video, o_Grn_Video, o_Blu_Video  out  VIDEO_WIDTH each  muxed, blanked video

## Operation
- **Counters**
  - Column counts 0..TOTAL_COLS-1 and wraps to 0.
  - Row increments when the column wraps. Row wraps to 0 after TOTAL_ROWS-1.
  - Reset loads column = TOTAL_COLS-1 and row = TOTAL_ROWS-1 internally. The first clock after reset release therefore wraps to (0,0) and performs a frame-boundary arbitration.
- **Sync**
  - o_HSync = (col < ACTIVE_COLS) and o_VSync = (row < ACTIVE_ROWS), registered together with the counts.
- **Arbiter FSM**
  - States: IDLE (no owner) and OWN (one owner).
  - The FSM is evaluated only on the wrap to (0,0). At all other times the state and o_Grant are held.
  - On wrap, the candidate search starts at the index after the last owner. After reset, the last owner is 3, so source 0 has first priority.
  - The first asserted i_Req found wins → OWN with that grant.
  - No asserted request → IDLE with o_Grant = 0. The last-owner pointer is unchanged.
  - If the owner is still requesting and another source is also requesting, the other source wins: fairness per frame.
  - If the owner is the only requester, it keeps the grant.
  - A request dropped mid-frame does not revoke the grant before the frame ends.
- **Video**
  - Output = granted source's pixel when o_HSync & o_VSync are high. Otherwise 0.
  - Output = 0 in IDLE.
- **Reset values**
  - All outputs 0, state IDLE.
  - Reset asserted mid-frame aborts immediately. No partial-frame completion.

## Timing
- Counts, sync, o_Frame_Start and o_Grant are all registered and change in the same cycle.
- o_Grant for a frame is valid on the cycle o_Frame_Start = 1, and is stable through (TOTAL_COLS-1, TOTAL_ROWS-1).
- Video has 1 cycle latency. The output at cycle t+1 is the source input sampled at cycle t, using the counts and grant output at cycle t. Sources compute their pixel combinationally from o_Col_Count/o_Row_Count.
- The downstream porch stage delays video by 2 cycles relative to its own sync. Alignment is that stage's responsibility.
- i_Req is sampled only on the wrap cycle. Changes to i_Req at any other time have no effect.

## Structure
- Shared package vga_pkg:
  - 640x480 constants: TOTAL_COLS=800, TOTAL_ROWS=525, ACTIVE_COLS=640, ACTIVE_ROWS=480.
  - Porch constants, so they live in one place.
  - NUM_SRC = 4.
  - Arbiter state encoding.
- Sub-module rr_arbiter_4:
  - Combinational round-robin pick from a 4-bit request vector and a 2-bit last-owner pointer.
  - Returns a one-hot grant plus a valid flag.
  - The top level registers its result on the wrap.

## Test plan
Use TOTAL_COLS=10, TOTAL_ROWS=6, ACTIVE_COLS=6, ACTIVE_ROWS=4 and VIDEO_WIDTH=3 for all scenarios.
- Reset, then release with i_Req=0 → first cycle shows (0,0) with o_Frame_Start=1 and o_Grant=0. Video stays 0 for the whole frame; the next o_Frame_Start arrives 60 cycles later.
- i_Req=4'b0010, source 1 red = 3'd5 → o_Grant=0010 at the next frame start. o_Red_Video=5 on the 6x4 active pixels, each 1 cycle after its count; 0 in blanking.
- i_Req=4'b0101 held for 3 frames → grants 0001, 0100, 0001.
- Owner 0010 drops i_Req at (3,2) → grant holds 0010 to frame end, then becomes 0 (IDLE).
- i_Req pulses 1000 only at (5,5) mid-frame → no grant change at the next frame start.
- Assert i_Rst at (4,3) while in OWN → outputs 0 immediately. After release, restart at (0,0) with source 0 first in priority.
